// File: rtl/reg_bank_reader.sv
// Read-side sequencer for a small register bank with an asynchronous read port.
// Walks a programmable address window and streams each captured word over valid/ready.
module reg_bank_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic load;
  logic last_word;

  assign load      = !out_valid_q || out_ready;
  assign last_word = (remaining_q == (ADDR_W+1)'(1));

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            cur_addr_d  = start_addr;
            remaining_d = count;
            state_d     = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = IDLE;
        end else if (load) begin
          // rd_data is the bank's async read of cur_addr, so it is captured on this edge.
          out_data_d  = rd_data;
          out_addr_d  = cur_addr_q;
          out_valid_d = 1'b1;
          out_last_d  = last_word;
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          if (last_word) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = IDLE;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_addr   = cur_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Scoreboard bench for reg_bank_reader: expected words are queued when a start is issued
// and a negedge monitor checks every presented word and every done pulse against them.
module tb_reg_bank_reader;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [2:0] start_addr;
  logic [3:0] count;
  logic       abort;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_addr;
  logic       out_last;
  logic       busy;
  logic       done;

  logic [7:0] mem [8];
  assign rd_data = mem[rd_addr];

  reg_bank_reader #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .count(count), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  logic exp_done = 1'b0;
  logic zero_start = 1'b0;

  int         ready_mode = 0;
  logic       ready_val = 1'b1;
  logic [5:0] ready_pat = 6'b101001;
  int         pidx = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // out_ready driver: constant, random, or the fixed 1,0,0,1,0,1 pattern
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: out_ready = ready_val;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          out_ready = ready_pat[pidx];
          pidx = (pidx + 1) % 6;
        end
      endcase
    end
  end

  // monitor: presented word must match the scoreboard head; done must match expectation
  initial begin
    logic nxt;
    exp_t e;
    forever begin
      @(negedge clk);
      chk("done", {31'd0, done}, {31'd0, exp_done});
      nxt = 1'b0;
      if (abort) begin
        sb.delete();
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got addr %0d data %0h with nothing expected", out_addr, out_data);
        end else begin
          e = sb[0];
          chk("out_addr", {29'd0, out_addr}, {29'd0, e.addr});
          chk("out_data", {24'd0, out_data}, {24'd0, e.data});
          chk("out_last", {31'd0, out_last}, {31'd0, e.last});
          if (out_ready) begin
            void'(sb.pop_front());
            popped++;
            nxt = e.last;
          end
        end
      end
      if (zero_start) nxt = 1'b1;
      exp_done = nxt;
    end
  end

  task automatic do_start(input logic [2:0] sa, input logic [3:0] cnt);
    exp_t e;
    for (int i = 0; i < int'(cnt); i++) begin
      e.addr = 3'((int'(sa) + i) % 8);
      e.data = mem[e.addr];
      e.last = (i == int'(cnt) - 1);
      sb.push_back(e);
    end
    zero_start = (cnt == 0);
    start = 1'b1;
    start_addr = sa;
    count = cnt;
    tick();
    start = 1'b0;
    zero_start = 1'b0;
  endtask

  task automatic wait_idle(input bit rand_events);
    int c;
    int r;
    c = 0;
    while (sb.size() != 0 && c < 400) begin
      r = rand_events ? $urandom_range(0, 59) : 99;
      if (r == 0) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end else if (r == 1) begin
        start = 1'b1;
        start_addr = 3'($urandom_range(0, 7));
        count = 4'($urandom_range(0, 8));
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
      c++;
    end
    if (c >= 400) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d words still pending", sb.size());
      sb.delete();
    end
    tick();
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic load_bank();
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
  endtask

  initial begin
    int c;
    start = 1'b0;
    start_addr = '0;
    count = '0;
    abort = 1'b0;
    load_bank();
    reset_n = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd_addr", {29'd0, rd_addr}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    reset_n = 1'b1;
    tick();

    // full sweep with latency check
    ready_mode = 0; ready_val = 1'b1;
    do_start(3'd0, 4'd8);
    @(negedge clk);
    chk("lat_valid_n1", {31'd0, out_valid}, 32'd0);
    chk("lat_busy_n1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("lat_valid_n2", {31'd0, out_valid}, 32'd1);
    #1;
    wait_idle(0);

    // wrap
    do_start(3'd6, 4'd4);
    wait_idle(0);

    // backpressure pattern
    pidx = 0; ready_mode = 2;
    do_start(3'd1, 4'd5);
    wait_idle(0);
    ready_mode = 0; ready_val = 1'b1;
    tick();

    // count=0 gives a bare done pulse
    do_start(3'd4, 4'd0);
    @(negedge clk);
    chk("zero_valid", {31'd0, out_valid}, 32'd0);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    #1;
    tick();

    // start while busy is ignored
    do_start(3'd0, 4'd4);
    tick();
    start = 1'b1; start_addr = 3'd5; count = 4'd3;
    tick();
    start = 1'b0;
    wait_idle(0);

    // abort after three words
    popped = 0;
    do_start(3'd0, 4'd8);
    c = 0;
    while (popped < 3 && c < 100) begin tick(); c++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    #1;
    tick();

    // asynchronous reset between edges
    do_start(3'd0, 4'd8);
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    sb.delete();
    exp_done = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rd_addr", {29'd0, rd_addr}, 32'd0);
    #10;
    reset_n = 1'b1;
    tick();
    do_start(3'd2, 4'd2);
    wait_idle(0);

    // capture timing: bank write after load must not alter the stalled word
    ready_val = 1'b0;
    tick();
    do_start(3'd3, 4'd2);
    c = 0;
    while (!out_valid && c < 20) begin @(negedge clk); c++; end
    chk("cap_seen", {31'd0, out_valid}, 32'd1);
    tick();
    mem[3] = 8'hAA;
    tick();
    tick();
    ready_val = 1'b1;
    wait_idle(0);
    mem[3] = 8'h13;

    // randomized readouts with random backpressure, aborts and ignored starts
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
      do_start(3'($urandom_range(0, 7)), 4'($urandom_range(0, 8)));
      wait_idle(1);
    end
    ready_mode = 0;
    tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
